// File: rtl/bank_arbiter_if.sv
// Bus bundle between the requesters/bank and the bank arbiter.
//   req_*        requester side: valid/we/packed addr/packed wdata in, one-hot ready out
//   rsp_*        one-hot read-response strobe and shared read data
//   bank_*       command to the bank and its read return
// slave modport is the arbiter's view, master modport is the requester/bank view.
interface bank_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]           rsp_data;
    logic [ADDR_WIDTH-1:0]           bank_addr;
    logic [DATA_WIDTH-1:0]           bank_data_in;
    logic                            bank_read_enable;
    logic                            bank_write_enable;
    logic [DATA_WIDTH-1:0]           bank_data_out;
    logic                            bank_valid_out;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bank_data_out, bank_valid_out,
        output req_ready, rsp_valid, rsp_data, bank_addr, bank_data_in,
               bank_read_enable, bank_write_enable
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bank_data_out, bank_valid_out,
        input  req_ready, rsp_valid, rsp_data, bank_addr, bank_data_in,
               bank_read_enable, bank_write_enable
    );
endinterface

// File: rtl/bank_arbiter.sv
// Round-robin front end for a single memory bank.
// Grants one requester per cycle (combinational one-hot req_ready), registers the
// accepted command towards the bank, and tracks outstanding reads in a tag pipeline
// so the bank's read return is steered back to the requester that issued it.
// Ports:
//   clk    in  clock, all state on posedge
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of bank_arbiter_if (requests, responses, bank command/return)
module bank_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    bank_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [PW-1:0]           ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]    grant;
    logic [PW-1:0]           gnt_id;
    logic [PW-1:0]           idx;
    logic                    found;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rd_en_q;
    logic                    wr_en_q;
    logic [PW-1:0]           cmd_id_q;

    logic [READ_LATENCY-1:0] tag_vld_q;
    logic [PW-1:0]           tag_id_q [READ_LATENCY];

    logic [NUM_PORTS-1:0]    rsp_valid;

    // Search from the pointer and wrap; NUM_PORTS is a power of two so the
    // PW-bit addition wraps for free.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr_q + PW'(k);
            if (!found && bus.req_valid[idx]) begin
                found       = 1'b1;
                gnt_id      = idx;
                grant[idx]  = 1'b1;
            end
        end
        ptr_d = found ? gnt_id + PW'(1) : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            cmd_id_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rd_en_q <= found & ~bus.req_we[gnt_id];
            wr_en_q <= found &  bus.req_we[gnt_id];
            if (found) begin
                addr_q   <= bus.req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q  <= bus.req_wdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                cmd_id_q <= gnt_id;
            end
        end
    end

    // Tag stage 0 is loaded in the same edge the bank samples read_enable, so the
    // last stage lines up with bank_valid_out READ_LATENCY cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_id_q[i] <= '0;
        end else begin
            tag_vld_q[0] <= rd_en_q;
            tag_id_q[0]  <= cmd_id_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // A return without a live tag is ignored; a live tag without a return is lost.
    always_comb begin
        rsp_valid = '0;
        if (bus.bank_valid_out && tag_vld_q[READ_LATENCY-1])
            rsp_valid[tag_id_q[READ_LATENCY-1]] = 1'b1;
    end

    assign bus.req_ready         = grant;
    assign bus.rsp_valid         = rsp_valid;
    assign bus.rsp_data          = bus.bank_data_out;
    assign bus.bank_addr         = addr_q;
    assign bus.bank_data_in      = wdata_q;
    assign bus.bank_read_enable  = rd_en_q;
    assign bus.bank_write_enable = wr_en_q;
endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a one-cycle-latency bank model.
module tb_bank_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bank_arbiter_if bus();

    bank_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bank model: registered read, valid one cycle after read_enable is sampled.
    logic [7:0] mem [256];
    logic       vq  = 1'b0;
    logic [7:0] dq  = 8'h00;
    logic       inj = 1'b0;
    logic       drop = 1'b0;

    always @(posedge clk) begin
        if (bus.bank_write_enable) mem[bus.bank_addr] <= bus.bank_data_in;
        vq <= bus.bank_read_enable;
        dq <= mem[bus.bank_addr];
    end

    assign bus.bank_valid_out = (vq & ~drop) | inj;
    assign bus.bank_data_out  = dq;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req;
        bus.req_valid = '0;
        bus.req_we    = '0;
    endtask

    task automatic drive(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        bus.req_valid[p]       = 1'b1;
        bus.req_we[p]          = we;
        bus.req_addr[p*8 +: 8]  = a;
        bus.req_wdata[p*8 +: 8] = d;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        idle_req();
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset = 1'b1;

        // 1: reset with no requests
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("idle_ctrl", {22'd0, bus.req_ready, bus.rsp_valid,
                                bus.bank_read_enable, bus.bank_write_enable}, 32'd0);
            check("idle_data", {8'd0, bus.rsp_data, bus.bank_addr, bus.bank_data_in}, 32'd0);
            cyc();
        end

        // 2: port 2 write then read-back
        drive(2, 1'b1, 8'd9, 8'd24);
        #1 check("wr_ready", {28'd0, bus.req_ready}, 32'b0100);
        cyc();
        idle_req();
        check("wr_cmd", {14'd0, bus.bank_read_enable, bus.bank_write_enable,
                         bus.bank_addr, bus.bank_data_in}, {14'd0, 2'b01, 8'd9, 8'd24});
        drive(2, 1'b0, 8'd9, 8'd0);
        #1 check("rd_ready", {28'd0, bus.req_ready}, 32'b0100);
        cyc();
        idle_req();
        check("rd_cmd", {30'd0, bus.bank_read_enable, bus.bank_write_enable}, 32'b10);
        check("rd_early", {28'd0, bus.rsp_valid}, 32'd0);
        cyc();
        check("rd_rsp", {20'd0, bus.rsp_valid, bus.rsp_data}, {20'd0, 4'b0100, 8'd24});

        // 3: all four ports read continuously from reset
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k < 8) for (int p = 0; p < 4; p++) drive(p, 1'b0, 8'(p), 8'd0);
            else idle_req();
            #1;
            if (k < 8) check("rr_grant", {28'd0, bus.req_ready}, 32'd1 << (k % 4));
            check("rr_re", {31'd0, bus.bank_read_enable}, (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
            check("rr_rsp", {28'd0, bus.rsp_valid},
                  (k >= 2) ? (32'd1 << ((k - 2) % 4)) : 32'd0);
        end

        // 4: pointer at 2 with ports 1 and 3 valid
        pulse_reset();
        cyc();
        drive(1, 1'b0, 8'd0, 8'd0);
        #1 check("p4_setup", {28'd0, bus.req_ready}, 32'b0010);
        cyc();
        drive(3, 1'b0, 8'd0, 8'd0);
        #1 check("p4_first", {28'd0, bus.req_ready}, 32'b1000);
        cyc();
        bus.req_valid[3] = 1'b0;
        #1 check("p4_second", {28'd0, bus.req_ready}, 32'b0010);
        cyc();
        idle_req();

        // 5: preload 255=145, 9=98, then back-to-back reads
        drive(0, 1'b1, 8'd255, 8'd145);
        #1 check("pre0", {28'd0, bus.req_ready}, 32'b0001);
        cyc();
        drive(0, 1'b1, 8'd9, 8'd98);
        #1 check("pre1", {28'd0, bus.req_ready}, 32'b0001);
        cyc();
        drive(0, 1'b0, 8'd255, 8'd0);
        #1 check("b2b_g0", {28'd0, bus.req_ready}, 32'b0001);
        cyc();
        idle_req();
        drive(1, 1'b0, 8'd9, 8'd0);
        #1 check("b2b_g1", {28'd0, bus.req_ready}, 32'b0010);
        cyc();
        idle_req();
        check("b2b_r0", {20'd0, bus.rsp_valid, bus.rsp_data}, {20'd0, 4'b0001, 8'd145});
        cyc();
        check("b2b_r1", {20'd0, bus.rsp_valid, bus.rsp_data}, {20'd0, 4'b0010, 8'd98});

        // 6: reset right after a read is accepted
        drive(3, 1'b0, 8'd9, 8'd0);
        #1 check("rst_g", {28'd0, bus.req_ready}, 32'b1000);
        cyc();
        idle_req();
        reset = 1'b1;
        #1 check("rst_en", {28'd0, bus.rsp_valid, bus.bank_read_enable, bus.bank_write_enable}, 32'd0);
        cyc();
        reset = 1'b0;
        check("rst_rsp0", {28'd0, bus.rsp_valid}, 32'd0);
        cyc();
        check("rst_rsp1", {28'd0, bus.rsp_valid}, 32'd0);
        for (int p = 0; p < 4; p++) drive(p, 1'b0, 8'd255, 8'd0);
        #1 check("rst_ptr", {28'd0, bus.req_ready}, 32'b0001);

        // 7: lost return and orphan return
        cyc();
        idle_req();
        cyc();
        drop = 1'b1;
        #1 check("drop", {28'd0, bus.rsp_valid}, 32'd0);
        cyc();
        drop = 1'b0;
        #1 check("no_retry", {28'd0, bus.rsp_valid}, 32'd0);
        inj = 1'b1;
        #1 check("orphan", {28'd0, bus.rsp_valid}, 32'd0);
        cyc();
        inj = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
